mix_in_sched: RTL and testbench
===============================

# mix_in_sched

Input-unit scheduler for the MIX core. Dispatches the CPU's IN instruction to one of several `in`-style input units and returns that unit's resume (`stop`) pulse to the CPU. Round-robin arbitration shares the single memory write port among all units' word-store requests. Sits between the CPU control sequencer, the memory write port and the unit array.

## Interface
Parameters:
- NUNITS, 4, number of attached input units (2..16)
- AW, 12, memory address width
- WW, 30, MIX word width (5 × 6-bit bytes)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  CPU issues IN; one-cycle pulse
- unit  in  4  F field: unit number
- addressin  in  AW  M field: buffer start address
- stop  out  1  CPU may resume; one-cycle pulse
- unit_err  out  1  pulse: unit ≥ NUNITS
- cpu_hold  in  1  CPU owns memory this cycle; no grant issued
- u_start  out  NUNITS  one-hot start pulse to unit
- u_address  out  AW  registered copy of addressin to units
- u_stop  in  NUNITS  per-unit resume pulse
- u_request  in  NUNITS  per-unit word-ready level
- u_addr  in  NUNITS*AW  per-unit store address (unit i at [i*AW +: AW])
- u_word  in  NUNITS*WW  per-unit word
- u_store  out  NUNITS  one-hot store acknowledge, one cycle
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  write address
- mem_data  out  WW  write data

## Operation
- Reset values: stop, unit_err, u_start, u_store and mem_we are 0; u_address, mem_addr and mem_data are 0; RR pointer is 0; FSM in IDLE; pending is invalid.
- Dispatch:
  - On start with unit < NUNITS, the next cycle drives u_start[unit]=1 and u_address=addressin. pending_unit ← unit, pending valid.
  - While pending is valid, stop = u_stop[pending_unit], registered with 1 cycle delay. The pulse clears pending.
  - u_stop from non-pending units is ignored.
- Invalid unit: on start with unit ≥ NUNITS, the next cycle drives unit_err=1 and stop=1. No u_start is issued.
- start while pending is valid: new pending_unit replaces the old one. The old unit's stop is not forwarded. The CPU must not do this; verification checks that the scheduler does not hang.
- Store FSM states: IDLE, WRITE, GAP.
  - IDLE → WRITE when (|u_request) & ~cpu_hold. Winner g is chosen from the RR pointer; g, its address and its word are latched.
  - WRITE, one cycle: mem_we=1, mem_addr/mem_data = latched values, u_store[g]=1. RR pointer ← g+1 mod NUNITS. Go to GAP.
  - GAP, one cycle: no grant is issued, which lets the unit drop u_request. Go to IDLE.
  - cpu_hold is sampled only in IDLE. Once a grant is latched it always completes.
- Round robin: search starts at the pointer and moves upward, wrapping from NUNITS-1 to 0.
- Dispatch and store paths are independent and may act in the same cycle.

## Timing
- start → u_start: 1 cycle.
- u_stop → stop: 1 cycle.
- u_request sampled in IDLE at cycle t → mem_we and u_store at t+1 → IDLE again at t+3. Peak throughput is one word per 3 cycles.
- Data is latched at grant, so u_word may change after u_store.
- Asynchronous reset mid-WRITE clears mem_we immediately. The partial store is lost; the unit keeps its request and re-requests after reset.

## Configuration
- MIX_IN_FIXED_PRIO_EN defined: fixed priority, lowest index wins. The RR pointer is not implemented.
- MIX_IN_FIXED_PRIO_EN undefined: round robin as in Operation.

## Structure
- Package mix_io_pkg holds:
  - AW and WW defaults
  - the MIX unit-number constants
  - the store-FSM state enum (IDLE/WRITE/GAP)
- Sub-module rr_arbiter (NUNITS-wide request vector, pointer in, one-hot grant out) contains the round-robin search. The fixed-priority variant compiles inside it.

## Test plan
- Reset and dispatch: reset low, then start with unit=2, addressin=100 → u_start=4'b0100 and u_address=100 one cycle later. Then u_stop[2] → stop pulse 1 cycle later.
- Invalid unit: start with unit=7 and NUNITS=4 → unit_err=1 and stop=1 for exactly one cycle; u_start stays 0.
- Contention: u_request=4'b1111 held, each unit dropping its request after its u_store → grants 0,1,2,3 in order, mem_we every 3 cycles. With MIX_IN_FIXED_PRIO_EN, grants are 0,1,2,3 only because each unit drops out.
- Fairness: units 1 and 3 re-request immediately after each store → grants alternate 1,3,1,3.
- CPU hold: cpu_hold=1 for 10 cycles with u_request[0]=1 → no mem_we. Grant follows 1 cycle after cpu_hold falls; mem_addr and mem_data equal unit 0's values (e.g. 100 and 30'h1234567).
- Reset mid-WRITE: assert reset during mem_we → mem_we and u_store go to 0 immediately, FSM returns to IDLE, and re-arbitration starts after reset is released.

Source files
------------

// File: rtl/mix_io_pkg.sv
// Shared constants and types for the MIX input-unit scheduler.
package mix_io_pkg;

    localparam int unsigned MIX_AW = 12;
    localparam int unsigned MIX_WW = 30;

    // MIX F-field unit numbers reachable through a 4-bit unit field
    localparam logic [3:0] UNIT_TAPE0 = 4'd0;
    localparam logic [3:0] UNIT_TAPE7 = 4'd7;
    localparam logic [3:0] UNIT_DISK0 = 4'd8;
    localparam logic [3:0] UNIT_DISK7 = 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StGap
    } store_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or above the pointer.
// MIX_IN_FIXED_PRIO_EN selects fixed priority (lowest index wins, pointer ignored).
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);

`ifdef MIX_IN_FIXED_PRIO_EN
    logic w_found;
    logic w_unused_ptr;

    assign w_unused_ptr = ^i_ptr;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            if (!w_found && i_req[k]) begin
                o_gnt[k] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end
`else
    logic [2*N-1:0] w_dbl;
    logic [PW-1:0]  w_off;
    logic [PW:0]    w_sum;
    logic [PW-1:0]  w_win;
    logic           w_found;
    logic           w_unused_hi;

    // Rotating the doubled vector puts the pointer position at bit 0
    assign w_dbl       = {i_req, i_req} >> i_ptr;
    assign w_unused_hi = ^w_dbl[2*N-1:N];

    always_comb begin
        w_off   = '0;
        w_found = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            if (!w_found && w_dbl[k]) begin
                w_off   = PW'(k);
                w_found = 1'b1;
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (PW + 1)'(N)) begin
            w_sum = w_sum - (PW + 1)'(N);
        end
        w_win = w_sum[PW-1:0];
        o_gnt = w_found ? (N'(1) << w_win) : '0;
    end
`endif

endmodule

// File: rtl/mix_in_sched.sv
// MIX IN-instruction scheduler: unit dispatch/resume plus shared memory write-port arbitration.
// Define MIX_IN_FIXED_PRIO_EN for fixed-priority store arbitration instead of round robin.
module mix_in_sched
    import mix_io_pkg::*;
#(
    parameter int unsigned NUNITS = 4,
    parameter int unsigned AW     = MIX_AW,
    parameter int unsigned WW     = MIX_WW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           unit,
    input  logic [AW-1:0]        addressin,
    output logic                 stop,
    output logic                 unit_err,
    input  logic                 cpu_hold,
    output logic [NUNITS-1:0]    u_start,
    output logic [AW-1:0]        u_address,
    input  logic [NUNITS-1:0]    u_stop,
    input  logic [NUNITS-1:0]    u_request,
    input  logic [NUNITS*AW-1:0] u_addr,
    input  logic [NUNITS*WW-1:0] u_word,
    output logic [NUNITS-1:0]    u_store,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [WW-1:0]        mem_data
);

    localparam int unsigned PW = (NUNITS > 1) ? $clog2(NUNITS) : 1;

    logic [NUNITS-1:0] r_u_start;
    logic [AW-1:0]     r_u_address;
    logic              r_stop;
    logic              r_unit_err;
    logic              r_pend_valid;
    logic [PW-1:0]     r_pend_unit;
    logic              w_unit_ok;
    logic [PW-1:0]     w_unit_idx;

    assign w_unit_ok  = 32'(unit) < NUNITS;
    assign w_unit_idx = unit[PW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_u_start    <= '0;
            r_u_address  <= '0;
            r_stop       <= 1'b0;
            r_unit_err   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_unit  <= '0;
        end else begin
            r_u_start  <= '0;
            r_stop     <= 1'b0;
            r_unit_err <= 1'b0;
            if (start) begin
                // A new IN replaces any pending one; the old unit's resume is dropped
                if (w_unit_ok) begin
                    r_u_start    <= NUNITS'(1) << w_unit_idx;
                    r_u_address  <= addressin;
                    r_pend_valid <= 1'b1;
                    r_pend_unit  <= w_unit_idx;
                end else begin
                    r_unit_err   <= 1'b1;
                    r_stop       <= 1'b1;
                    r_pend_valid <= 1'b0;
                end
            end else if (r_pend_valid && u_stop[r_pend_unit]) begin
                r_stop       <= 1'b1;
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign u_start   = r_u_start;
    assign u_address = r_u_address;
    assign stop      = r_stop;
    assign unit_err  = r_unit_err;

    store_state_e      r_state;
    logic              r_mem_we;
    logic [NUNITS-1:0] r_u_store;
    logic [AW-1:0]     r_mem_addr;
    logic [WW-1:0]     r_mem_data;
    logic [PW-1:0]     w_ptr;
    logic [NUNITS-1:0] w_gnt;
    logic [PW-1:0]     w_win_idx;
    logic [AW-1:0]     w_win_addr;
    logic [WW-1:0]     w_win_word;

`ifdef MIX_IN_FIXED_PRIO_EN
    logic w_unused_idx;

    assign w_ptr        = '0;
    assign w_unused_idx = ^w_win_idx;
`else
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_g;

    assign w_ptr = r_ptr;
`endif

    rr_arbiter #(
        .N  (NUNITS),
        .PW (PW)
    ) u_arb (
        .i_req (u_request),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_win_idx  = '0;
        w_win_addr = '0;
        w_win_word = '0;
        for (int i = 0; i < int'(NUNITS); i++) begin
            if (w_gnt[i]) begin
                w_win_idx  = PW'(i);
                w_win_addr = u_addr[i*AW +: AW];
                w_win_word = u_word[i*WW +: WW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_mem_we   <= 1'b0;
            r_u_store  <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
`ifndef MIX_IN_FIXED_PRIO_EN
            r_ptr      <= '0;
            r_g        <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if ((|u_request) && !cpu_hold) begin
                        r_mem_we   <= 1'b1;
                        r_u_store  <= w_gnt;
                        r_mem_addr <= w_win_addr;
                        r_mem_data <= w_win_word;
`ifndef MIX_IN_FIXED_PRIO_EN
                        r_g        <= w_win_idx;
`endif
                        r_state    <= StWrite;
                    end
                end
                StWrite: begin
                    r_mem_we  <= 1'b0;
                    r_u_store <= '0;
`ifndef MIX_IN_FIXED_PRIO_EN
                    r_ptr     <= (r_g == PW'(NUNITS - 1)) ? '0 : r_g + PW'(1);
`endif
                    r_state   <= StGap;
                end
                // Idle cycle so the granted unit can drop its request
                StGap:   r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign mem_we   = r_mem_we;
    assign u_store  = r_u_store;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;

endmodule

// File: tb/tb_mix_in_sched.sv
// Directed bench for mix_in_sched: dispatch, invalid unit, store arbitration, hold, reset.
module tb_mix_in_sched;

    localparam int NU = 4;
    localparam int AWT = 12;
    localparam int WWT = 30;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [3:0]        unit;
    logic [AWT-1:0]    addressin;
    logic              stop;
    logic              unit_err;
    logic              cpu_hold;
    logic [NU-1:0]     u_start;
    logic [AWT-1:0]    u_address;
    logic [NU-1:0]     u_stop;
    logic [NU-1:0]     u_request;
    logic [NU*AWT-1:0] u_addr;
    logic [NU*WWT-1:0] u_word;
    logic [NU-1:0]     u_store;
    logic              mem_we;
    logic [AWT-1:0]    mem_addr;
    logic [WWT-1:0]    mem_data;

    int n_cmp = 0;
    int n_fail = 0;

    mix_in_sched #(
        .NUNITS (NU),
        .AW     (AWT),
        .WW     (WWT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .unit      (unit),
        .addressin (addressin),
        .stop      (stop),
        .unit_err  (unit_err),
        .cpu_hold  (cpu_hold),
        .u_start   (u_start),
        .u_address (u_address),
        .u_stop    (u_stop),
        .u_request (u_request),
        .u_addr    (u_addr),
        .u_word    (u_word),
        .u_store   (u_store),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; unit = '0; addressin = '0; cpu_hold = 1'b0;
        u_stop = '0; u_request = '0; u_addr = '0; u_word = '0;
        tick(); tick();
        n_cmp++;
        if ({stop, unit_err, mem_we} !== 3'b000) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 000", {stop, unit_err, mem_we});
        end
        n_cmp++;
        if ({u_start, u_store} !== 8'h00) begin
            n_fail++; $display("FAIL reset_onehots: got %h want 00", {u_start, u_store});
        end
        n_cmp++;
        if ({u_address, mem_addr, mem_data} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h want 0", u_address, mem_addr, mem_data);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_dispatch();
        start = 1'b1; unit = 4'd2; addressin = 12'd100;
        tick();
        start = 1'b0;
        n_cmp++;
        if (u_start !== 4'b0100) begin
            n_fail++; $display("FAIL dispatch_u_start: got %b want 0100", u_start);
        end
        n_cmp++;
        if (u_address !== 12'd100) begin
            n_fail++; $display("FAIL dispatch_u_address: got %0d want 100", u_address);
        end
        tick();
        n_cmp++;
        if (u_start !== 4'b0000) begin
            n_fail++; $display("FAIL dispatch_u_start_pulse: got %b want 0000", u_start);
        end
        u_stop = 4'b1000;  // non-pending unit is ignored
        tick();
        u_stop = 4'b0000;
        n_cmp++;
        if (stop !== 1'b0) begin
            n_fail++; $display("FAIL dispatch_foreign_stop: got %b want 0", stop);
        end
        u_stop = 4'b0100;
        tick();
        u_stop = 4'b0000;
        n_cmp++;
        if (stop !== 1'b1) begin
            n_fail++; $display("FAIL dispatch_stop: got %b want 1", stop);
        end
        u_stop = 4'b0100;  // pending already cleared
        tick();
        u_stop = 4'b0000;
        n_cmp++;
        if (stop !== 1'b0) begin
            n_fail++; $display("FAIL dispatch_stop_once: got %b want 0", stop);
        end
    endtask

    task automatic test_invalid_unit();
        start = 1'b1; unit = 4'd7; addressin = 12'd55;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({unit_err, stop, u_start} !== 6'b110000) begin
            n_fail++; $display("FAIL invalid_unit: got err=%b stop=%b u_start=%b want 1 1 0000",
                               unit_err, stop, u_start);
        end
        n_cmp++;
        if (u_address !== 12'd100) begin
            n_fail++; $display("FAIL invalid_u_address: got %0d want 100", u_address);
        end
        tick();
        n_cmp++;
        if ({unit_err, stop} !== 2'b00) begin
            n_fail++; $display("FAIL invalid_one_cycle: got err=%b stop=%b want 0 0", unit_err, stop);
        end
    endtask

    task automatic test_back_to_back_start();
        start = 1'b1; unit = 4'd1; addressin = 12'd200;
        tick();
        unit = 4'd3; addressin = 12'd300;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({u_start, u_address} !== {4'b1000, 12'd300}) begin
            n_fail++; $display("FAIL b2b_start: got %b %0d want 1000 300", u_start, u_address);
        end
        u_stop = 4'b0010;
        tick();
        u_stop = 4'b0000;
        n_cmp++;
        if (stop !== 1'b0) begin
            n_fail++; $display("FAIL b2b_old_stop: got %b want 0", stop);
        end
        u_stop = 4'b1000;
        tick();
        u_stop = 4'b0000;
        n_cmp++;
        if (stop !== 1'b1) begin
            n_fail++; $display("FAIL b2b_new_stop: got %b want 1", stop);
        end
    endtask

    task automatic test_contention();
        int ng;
        int last;
        for (int i = 0; i < NU; i++) begin
            u_addr[i*AWT +: AWT] = AWT'(10 + i);
            u_word[i*WWT +: WWT] = WWT'(32'h100 + i);
        end
        u_request = 4'b1111;
        ng = 0;
        last = -1;
        for (int c = 1; c <= 40 && ng < NU; c++) begin
            tick();
            if (mem_we) begin
                u_word[ng*WWT +: WWT] = 30'h3FFF_FFFF;  // word already latched
                #1;
                n_cmp++;
                if (u_store !== 4'(1 << ng)) begin
                    n_fail++; $display("FAIL contention_grant%0d: got %b want %b", ng, u_store, 4'(1 << ng));
                end
                n_cmp++;
                if ({mem_addr, mem_data} !== {AWT'(10 + ng), WWT'(32'h100 + ng)}) begin
                    n_fail++; $display("FAIL contention_data%0d: got %0d %h want %0d %h", ng, mem_addr,
                                       mem_data, 10 + ng, 32'h100 + ng);
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (c - last !== 3) begin
                        n_fail++; $display("FAIL contention_spacing%0d: got %0d want 3", ng, c - last);
                    end
                end
                last = c;
                u_request[ng] = 1'b0;
                ng++;
            end
        end
        n_cmp++;
        if (ng !== NU) begin
            n_fail++; $display("FAIL contention_count: got %0d want %0d", ng, NU);
        end
        u_request = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_fairness();
        int ng;
        int exp_g;
        for (int i = 0; i < NU; i++) begin
            u_word[i*WWT +: WWT] = WWT'(32'h200 + i);
        end
        u_request = 4'b1010;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            tick();
            if (mem_we) begin
                exp_g = (ng % 2 == 0) ? 1 : 3;
                n_cmp++;
                if (u_store !== 4'(1 << exp_g)) begin
                    n_fail++; $display("FAIL fairness_grant%0d: got %b want %b", ng, u_store, 4'(1 << exp_g));
                end
                ng++;
            end
        end
        n_cmp++;
        if (ng !== 4) begin
            n_fail++; $display("FAIL fairness_count: got %0d want 4", ng);
        end
        u_request = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_cpu_hold();
        int seen;
        u_addr[0 +: AWT] = 12'd100;
        u_word[0 +: WWT] = 30'h1234567;
        cpu_hold = 1'b1;
        u_request = 4'b0001;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (mem_we !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL hold_no_write: got %0d writes want 0", seen);
        end
        cpu_hold = 1'b0;
        tick();
        n_cmp++;
        if ({mem_we, u_store} !== 5'b10001) begin
            n_fail++; $display("FAIL hold_release_grant: got we=%b store=%b want 1 0001", mem_we, u_store);
        end
        n_cmp++;
        if ({mem_addr, mem_data} !== {12'd100, 30'h1234567}) begin
            n_fail++; $display("FAIL hold_release_data: got %0d %h want 100 1234567", mem_addr, mem_data);
        end
        u_request = '0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_write();
        u_request = 4'b0001;
        tick();
        n_cmp++;
        if (mem_we !== 1'b1) begin
            n_fail++; $display("FAIL rstwr_pre: got we=%b want 1", mem_we);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({mem_we, u_store} !== 5'b00000) begin
            n_fail++; $display("FAIL rstwr_async_clear: got we=%b store=%b want 0 0000", mem_we, u_store);
        end
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({mem_we, u_store} !== 5'b10001) begin
            n_fail++; $display("FAIL rstwr_rearb: got we=%b store=%b want 1 0001", mem_we, u_store);
        end
        u_request = '0;
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_invalid_unit();
        test_back_to_back_start();
        test_contention();
        test_fairness();
        test_cpu_hold();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
